// File: rtl/io_predication_pipelined.sv
// I/O predication: decodes per-memory accesses that hit the I/O port window, registers readiness
// and one-hot read enables, and gates reads with cancel. Optional stall counter: IO_PREDICATION_STALL_COUNT_EN.
module io_predication_pipelined #(
    parameter int MEM_COUNT        = 2,
    parameter int READ_ADDR_WIDTH  = 10,
    parameter int WRITE_ADDR_WIDTH = 12,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter logic [MEM_COUNT*READ_ADDR_WIDTH-1:0]  MEM_READ_BASE_ADDRS   = '0,
    parameter logic [MEM_COUNT*READ_ADDR_WIDTH-1:0]  MEM_READ_BOUND_ADDRS  = '0,
    parameter logic [MEM_COUNT*WRITE_ADDR_WIDTH-1:0] MEM_WRITE_BASE_ADDRS  = '0,
    parameter logic [MEM_COUNT*WRITE_ADDR_WIDTH-1:0] MEM_WRITE_BOUND_ADDRS = '0,
    parameter int PORT_COUNT       = 8,
    parameter int PORT_BASE_ADDR   = 1016,
    parameter int PORT_ADDR_WIDTH  = 3,
    parameter int STALL_CNT_WIDTH  = 8,
    parameter int STALL_LIMIT      = 255
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  cancel,
    input  logic [MEM_COUNT*READ_ADDR_WIDTH-1:0]  read_addr,
    input  logic [MEM_COUNT*WRITE_ADDR_WIDTH-1:0] write_addr,
    input  logic [MEM_COUNT*PORT_COUNT-1:0]       read_EF,
    input  logic [MEM_COUNT*PORT_COUNT-1:0]       write_EF,
    output logic [MEM_COUNT*PORT_COUNT-1:0]       io_rden,
    output logic [MEM_COUNT-1:0]                  read_addr_is_IO,
    output logic [MEM_COUNT-1:0]                  write_addr_is_IO,
    output logic                                  IO_ready,
    output logic [STALL_CNT_WIDTH-1:0]            stall_count,
    output logic                                  io_timeout
);

    localparam logic [MEM_ADDR_WIDTH:0] PORT_LO = (MEM_ADDR_WIDTH+1)'(PORT_BASE_ADDR);
    localparam logic [MEM_ADDR_WIDTH:0] PORT_HI = (MEM_ADDR_WIDTH+1)'(PORT_BASE_ADDR + PORT_COUNT - 1);

    function automatic logic rd_in_window(input logic [READ_ADDR_WIDTH-1:0] addr,
                                          input logic [READ_ADDR_WIDTH-1:0] lo,
                                          input logic [READ_ADDR_WIDTH-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic logic wr_in_window(input logic [WRITE_ADDR_WIDTH-1:0] addr,
                                          input logic [WRITE_ADDR_WIDTH-1:0] lo,
                                          input logic [WRITE_ADDR_WIDTH-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic logic is_port(input logic [MEM_ADDR_WIDTH-1:0] loc);
        logic [MEM_ADDR_WIDTH:0] ext;
        ext = {1'b0, loc};
        return (ext >= PORT_LO) && (ext <= PORT_HI);
    endfunction

    if (STALL_LIMIT >= (2 ** STALL_CNT_WIDTH)) begin : g_bad_stall_limit
        $error("STALL_LIMIT does not fit in STALL_CNT_WIDTH bits");
    end

    logic [MEM_COUNT-1:0]            rd_io_s, wr_io_s, rd_ok_s, wr_ok_s;
    logic [MEM_COUNT*PORT_COUNT-1:0] rden_raw_s;
    logic [MEM_COUNT-1:0]            rd_io_r, wr_io_r;
    logic [MEM_COUNT*PORT_COUNT-1:0] rden_raw_r;
    logic                            io_ready_r;

    for (genvar m = 0; m < MEM_COUNT; m++) begin : g_mem
        logic [READ_ADDR_WIDTH-1:0]  rd_a_s;
        logic [WRITE_ADDR_WIDTH-1:0] wr_a_s;
        logic [MEM_ADDR_WIDTH-1:0]   rd_loc_s, wr_loc_s;
        logic [PORT_ADDR_WIDTH-1:0]  rd_idx_s, wr_idx_s;
        logic [PORT_COUNT-1:0]       rd_oh_s, wr_oh_s;

        assign rd_a_s   = read_addr[m*READ_ADDR_WIDTH +: READ_ADDR_WIDTH];
        assign wr_a_s   = write_addr[m*WRITE_ADDR_WIDTH +: WRITE_ADDR_WIDTH];
        assign rd_loc_s = rd_a_s[MEM_ADDR_WIDTH-1:0];
        assign wr_loc_s = wr_a_s[MEM_ADDR_WIDTH-1:0];
        assign rd_idx_s = PORT_ADDR_WIDTH'(rd_loc_s - MEM_ADDR_WIDTH'(PORT_BASE_ADDR));
        assign wr_idx_s = PORT_ADDR_WIDTH'(wr_loc_s - MEM_ADDR_WIDTH'(PORT_BASE_ADDR));

        assign rd_io_s[m] = rd_in_window(rd_a_s,
                                         MEM_READ_BASE_ADDRS[m*READ_ADDR_WIDTH +: READ_ADDR_WIDTH],
                                         MEM_READ_BOUND_ADDRS[m*READ_ADDR_WIDTH +: READ_ADDR_WIDTH])
                            && is_port(rd_loc_s);
        assign wr_io_s[m] = wr_in_window(wr_a_s,
                                         MEM_WRITE_BASE_ADDRS[m*WRITE_ADDR_WIDTH +: WRITE_ADDR_WIDTH],
                                         MEM_WRITE_BOUND_ADDRS[m*WRITE_ADDR_WIDTH +: WRITE_ADDR_WIDTH])
                            && is_port(wr_loc_s);

        // one-hot port select, empty for non-I/O accesses
        always_comb begin
            rd_oh_s = '0;
            wr_oh_s = '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                rd_oh_s[p] = rd_io_s[m] && (rd_idx_s == PORT_ADDR_WIDTH'(p));
                wr_oh_s[p] = wr_io_s[m] && (wr_idx_s == PORT_ADDR_WIDTH'(p));
            end
        end

        // a non-I/O access never blocks, an I/O access needs its port's EF
        assign rd_ok_s[m] = ~rd_io_s[m] | (|(rd_oh_s & read_EF[m*PORT_COUNT +: PORT_COUNT]));
        assign wr_ok_s[m] = ~wr_io_s[m] | (|(wr_oh_s & write_EF[m*PORT_COUNT +: PORT_COUNT]));
        assign rden_raw_s[m*PORT_COUNT +: PORT_COUNT] = rd_oh_s;
    end

    // decode pipeline register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_io_r    <= '0;
            wr_io_r    <= '0;
            io_ready_r <= 1'b1;
            rden_raw_r <= '0;
        end else begin
            rd_io_r    <= rd_io_s;
            wr_io_r    <= wr_io_s;
            io_ready_r <= &{rd_ok_s, wr_ok_s};
            rden_raw_r <= rden_raw_s;
        end
    end

    assign read_addr_is_IO  = rd_io_r;
    assign write_addr_is_IO = wr_io_r;
    assign IO_ready         = io_ready_r;
    // cancel arrives in the output cycle, so the gate stays combinational
    assign io_rden = rden_raw_r & {(MEM_COUNT*PORT_COUNT){~(cancel | ~io_ready_r)}};

`ifdef IO_PREDICATION_STALL_COUNT_EN
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_LIMIT_C = STALL_CNT_WIDTH'(STALL_LIMIT);

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_r, stall_cnt_next_s;
    logic                       timeout_r;

    // saturating stall count; a cancelled stall cycle holds the count
    always_comb begin
        stall_cnt_next_s = stall_cnt_r;
        if (io_ready_r) begin
            stall_cnt_next_s = '0;
        end else if (!cancel && (stall_cnt_r != STALL_LIMIT_C)) begin
            stall_cnt_next_s = stall_cnt_r + STALL_CNT_WIDTH'(1);
        end else begin
            stall_cnt_next_s = stall_cnt_r;
        end
    end

    // stall counter and timeout flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
            timeout_r   <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_next_s;
            timeout_r   <= (stall_cnt_next_s == STALL_LIMIT_C);
        end
    end

    assign stall_count = stall_cnt_r;
    assign io_timeout  = timeout_r;
`else
    assign stall_count = '0;
    assign io_timeout  = 1'b0;
`endif

endmodule
